clk_div_ctrl: RTL

//   Run-time controller for the 50 MHz square-wave divider. It owns the divider

---
 rtl/clk_div_ctrl_if.sv | 35 +++
 rtl/clk_div_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/clk_div_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_ctrl_if
//  Description : Configuration handshake bundle for clk_div_ctrl.
//                master drives cfg_valid / cfg_half,
//                slave (the controller) returns cfg_ready / cfg_err.
//  Ports       : cfg_valid  - a half-period word is offered
//                cfg_half   - offered terminal count (CNT_W bits)
//                cfg_ready  - controller accepts a word this cycle
//                cfg_err    - one-cycle pulse, accepted word was rejected
//  Revision    : 1.0 - initial release
// ============================================================================
interface clk_div_ctrl_if #(
    parameter int CNT_W = 25
);
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_half;
    logic             cfg_ready;
    logic             cfg_err;

    modport master (
        output cfg_valid,
        output cfg_half,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_half,
        output cfg_ready,
        output cfg_err
    );
endinterface
`default_nettype wire

// File: rtl/clk_div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_ctrl
//  Description : Run-time controller for the square-wave clock divider.
//                Owns the divider counter and half-period register, starts
//                and stops clk_out without runt pulses, and applies new
//                half-period values only at full-period boundaries.
//  Ports       : clk_50mhz - system clock
//                rst       - asynchronous active-high reset
//                en        - run request (1 = run, 0 = stop cleanly)
//                cfg       - cfg handshake (slave side of clk_div_ctrl_if)
//                clk_out   - divided square wave (registered)
//                tick      - one-cycle pulse in the cycle clk_out toggled
//                half_cur  - half-period terminal count in use
//                state     - 00 STOP, 01 RUN, 10 PEND
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_div_ctrl #(
    parameter int CNT_W    = 25,
    parameter int DEF_HALF = 24_999_999,
    parameter int MIN_HALF = 1
) (
    input  wire logic             clk_50mhz,
    input  wire logic             rst,
    input  wire logic             en,
    clk_div_ctrl_if.slave         cfg,
    output logic                  clk_out,
    output logic                  tick,
    output logic [CNT_W-1:0]      half_cur,
    output logic [1:0]            state
);

    localparam logic [CNT_W-1:0] c_def_half = CNT_W'(DEF_HALF);
    localparam logic [CNT_W-1:0] c_min_half = CNT_W'(MIN_HALF);

    typedef enum logic [1:0] {
        ST_STOP = 2'b00,
        ST_RUN  = 2'b01,
        ST_PEND = 2'b10
    } state_t;

    state_t           r_state,   w_state_nxt;
    logic [CNT_W-1:0] r_counter, w_counter_nxt;
    logic [CNT_W-1:0] r_half,    w_half_nxt;
    logic [CNT_W-1:0] r_pend,    w_pend_nxt;
    logic             r_clk_out, w_clk_out_nxt;
    logic             r_tick,    w_tick_nxt;
    logic             r_ready,   w_ready_nxt;
    logic             r_err,     w_err_nxt;

    logic             w_acc;
    logic             w_bad;
    logic             w_good;
    logic             w_tc;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_50mhz or posedge rst) begin
        if (rst) begin
            r_state   <= ST_STOP;
            r_counter <= '0;
            r_half    <= c_def_half;
            r_pend    <= '0;
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
            r_ready   <= 1'b1;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_counter <= w_counter_nxt;
            r_half    <= w_half_nxt;
            r_pend    <= w_pend_nxt;
            r_clk_out <= w_clk_out_nxt;
            r_tick    <= w_tick_nxt;
            r_ready   <= w_ready_nxt;
            r_err     <= w_err_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        // A word transfers whenever valid meets ready; too-small words still
        // transfer but are dropped and flagged on the following cycle.
        w_acc  = cfg.cfg_valid & r_ready;
        w_bad  = w_acc & (cfg.cfg_half < c_min_half);
        w_good = w_acc & ~w_bad;
        w_tc   = (r_counter == r_half);

        w_state_nxt   = r_state;
        w_counter_nxt = r_counter;
        w_half_nxt    = r_half;
        w_pend_nxt    = r_pend;
        w_clk_out_nxt = r_clk_out;
        w_tick_nxt    = 1'b0;
        w_ready_nxt   = r_ready;
        w_err_nxt     = w_bad;

        case (r_state)
            ST_STOP: begin
                w_counter_nxt = '0;
                w_clk_out_nxt = 1'b0;
                w_ready_nxt   = 1'b1;
                if (w_good) begin
                    w_half_nxt = cfg.cfg_half;
                end
                if (en) begin
                    w_state_nxt = ST_RUN;
                end
            end

            ST_RUN, ST_PEND: begin
                if (!en && !r_clk_out) begin
                    // Low phase: stopping now cannot shorten a high pulse.
                    // The counter restarts at 0, so a waiting or freshly
                    // accepted value can be installed safely here.
                    w_state_nxt   = ST_STOP;
                    w_counter_nxt = '0;
                    w_clk_out_nxt = 1'b0;
                    w_ready_nxt   = 1'b1;
                    if (r_state == ST_PEND) begin
                        w_half_nxt = r_pend;
                    end else if (w_good) begin
                        w_half_nxt = cfg.cfg_half;
                    end
                end else begin
                    if (w_tc) begin
                        w_counter_nxt = '0;
                        w_clk_out_nxt = ~r_clk_out;
                        w_tick_nxt    = 1'b1;
                    end else begin
                        w_counter_nxt = r_counter + 1'b1;
                    end

                    if (w_tc && r_clk_out) begin
                        // Falling toggle closes a full period: the only place
                        // half_cur may change while running.
                        if (r_state == ST_PEND) begin
                            w_half_nxt  = r_pend;
                            w_ready_nxt = 1'b1;
                        end
                        if (!en) begin
                            w_state_nxt = ST_STOP;
                            if (w_good) begin
                                w_half_nxt = cfg.cfg_half;
                            end
                        end else if (w_good) begin
                            w_pend_nxt  = cfg.cfg_half;
                            w_ready_nxt = 1'b0;
                            w_state_nxt = ST_PEND;
                        end else begin
                            w_state_nxt = ST_RUN;
                        end
                    end else if (w_good) begin
                        // Only reachable from RUN: cfg_ready is low in PEND.
                        w_pend_nxt  = cfg.cfg_half;
                        w_ready_nxt = 1'b0;
                        w_state_nxt = ST_PEND;
                    end
                end
            end

            default: begin
                w_state_nxt = ST_STOP;
            end
        endcase
    end

    assign cfg.cfg_ready = r_ready;
    assign cfg.cfg_err   = r_err;
    assign clk_out       = r_clk_out;
    assign tick          = r_tick;
    assign half_cur      = r_half;
    assign state         = r_state;

endmodule
`default_nettype wire
